// File: rtl/sd_arb_pkg.sv
// Shared types and helpers for the SD-block drive arbiter.
package sd_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ISSUE,
    XFER,
    DONE,
    ABORT
  } arb_state_t;

  // Index width that stays at least 1 bit wide for a single-drive build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int            p;
  logic [IW-1:0] pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    p     = 0;
    pos   = '0;
    for (int off = 0; off < N; off++) begin
      p   = (int'(ptr) + off) % N;
      pos = IW'(p);
      if (!valid && req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/sd_drive_arbiter.sv
// Round-robin arbiter between NDRV disk clients and the hps_io SD-block port,
// one sector transfer in flight, with per-transfer LBA latch and no-ack timeout.
module sd_drive_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NDRV   = 4,
  parameter int LBA_W  = 32,
  parameter int BUF_AW = 9,
  parameter int DW     = 8,
  parameter int TO_W   = 24,
  parameter int TO_EN  = 1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [NDRV*LBA_W-1:0] cl_lba,
  input  logic [NDRV-1:0]       cl_rd,
  input  logic [NDRV-1:0]       cl_wr,
  output logic [NDRV-1:0]       cl_busy,
  output logic [NDRV-1:0]       cl_done,
  output logic [NDRV-1:0]       cl_err,
  input  logic [NDRV*DW-1:0]    cl_buff_din,
  output logic [BUF_AW-1:0]     cl_buff_addr,
  output logic [DW-1:0]         cl_buff_dout,
  output logic [NDRV-1:0]       cl_buff_wr,
  output logic [NDRV*LBA_W-1:0] hps_lba,
  output logic [NDRV-1:0]       hps_rd,
  output logic [NDRV-1:0]       hps_wr,
  input  logic [NDRV-1:0]       hps_ack,
  input  logic [BUF_AW-1:0]     hps_buff_addr,
  input  logic [DW-1:0]         hps_buff_dout,
  input  logic                  hps_buff_wr,
  output logic [DW-1:0]         hps_buff_din
);

  localparam int IDX_W = idx_width(NDRV);
  // ISSUE may last 2^TO_W-1 cycles; the last one is seen at count 2^TO_W-2.
  localparam logic [TO_W-1:0] TO_LAST = ~TO_W'(1);

  arb_state_t        state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [IDX_W-1:0]  ptr_reg, ptr_next;
  logic [LBA_W-1:0]  lba_reg, lba_next;
  logic              wr_reg, wr_next;
  logic [TO_W-1:0]   cnt_reg, cnt_next;

  logic [NDRV-1:0]   req;
  logic [NDRV-1:0]   pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [IDX_W-1:0]  ptr_after;
  logic              ack_sel;
  logic              owning;
  logic              in_xfer;
  logic              busy_st;

  assign req     = cl_rd | cl_wr;
  assign ack_sel = hps_ack[idx_reg];

  rr_arbiter #(
    .N  (NDRV),
    .IW (IDX_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_reg),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign ptr_after = (idx_reg == IDX_W'(NDRV - 1)) ? '0 : idx_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    ptr_next   = ptr_reg;
    lba_next   = lba_reg;
    wr_next    = wr_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|req) state_next = GRANT;
      end
      GRANT: begin
        if (pick_valid) begin
          idx_next   = pick_idx;
          lba_next   = cl_lba[pick_idx*LBA_W +: LBA_W];
          // Write wins when a drive raises both rd and wr.
          wr_next    = |(cl_wr & pick_gnt);
          cnt_next   = '0;
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        if (ack_sel) begin
          state_next = XFER;
        end else if (TO_EN != 0 && cnt_reg == TO_LAST) begin
          state_next = ABORT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      XFER: begin
        if (!ack_sel) state_next = DONE;
      end
      DONE, ABORT: begin
        ptr_next   = ptr_after;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      ptr_reg   <= '0;
      lba_reg   <= '0;
      wr_reg    <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ptr_reg   <= ptr_next;
      lba_reg   <= lba_next;
      wr_reg    <= wr_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign owning  = (state_reg == ISSUE) || (state_reg == XFER);
  assign in_xfer = (state_reg == XFER);
  assign busy_st = owning || (state_reg == DONE) || (state_reg == ABORT);

  generate
    for (genvar gi = 0; gi < NDRV; gi++) begin : g_drv
      logic sel;
      assign sel            = (idx_reg == IDX_W'(gi));
      assign cl_busy[gi]    = busy_st && sel;
      assign cl_done[gi]    = (state_reg == DONE) && sel;
      assign cl_err[gi]     = (state_reg == ABORT) && sel;
      assign hps_rd[gi]     = owning && sel && !wr_reg;
      assign hps_wr[gi]     = owning && sel && wr_reg;
      assign cl_buff_wr[gi] = in_xfer && sel && hps_buff_wr;
      assign hps_lba[gi*LBA_W +: LBA_W] = (owning && sel) ? lba_reg : '0;
    end
  endgenerate

  // Buffer bus is only meaningful to the granted drive while data moves.
  assign cl_buff_addr = in_xfer ? hps_buff_addr : '0;
  assign cl_buff_dout = in_xfer ? hps_buff_dout : '0;
  assign hps_buff_din = owning ? cl_buff_din[idx_reg*DW +: DW] : '0;

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// Self-checking bench for sd_drive_arbiter: directed scenarios plus randomized
// transfers checked against a round-robin reference model.
module tb_sd_drive_arbiter;

  localparam int N  = 4;
  localparam int LW = 32;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int TW = 4;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic [N*LW-1:0] cl_lba;
  logic [N-1:0]    cl_rd, cl_wr, cl_busy, cl_done, cl_err, cl_buff_wr;
  logic [N*DW-1:0] cl_buff_din;
  logic [AW-1:0]   cl_buff_addr, hps_buff_addr;
  logic [DW-1:0]   cl_buff_dout, hps_buff_dout, hps_buff_din;
  logic [N*LW-1:0] hps_lba;
  logic [N-1:0]    hps_rd, hps_wr, hps_ack;
  logic            hps_buff_wr;

  int tests = 0;
  int fails = 0;
  int ptr_m = 0;
  logic [LW-1:0] exp_lba [N];
  logic [DW-1:0] exp_din [N];
  logic          exp_wr  [N];

  sd_drive_arbiter #(
    .NDRV(N), .LBA_W(LW), .BUF_AW(AW), .DW(DW), .TO_W(TW), .TO_EN(1)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .cl_lba(cl_lba), .cl_rd(cl_rd), .cl_wr(cl_wr),
    .cl_busy(cl_busy), .cl_done(cl_done), .cl_err(cl_err), .cl_buff_din(cl_buff_din),
    .cl_buff_addr(cl_buff_addr), .cl_buff_dout(cl_buff_dout), .cl_buff_wr(cl_buff_wr),
    .hps_lba(hps_lba), .hps_rd(hps_rd), .hps_wr(hps_wr), .hps_ack(hps_ack),
    .hps_buff_addr(hps_buff_addr), .hps_buff_dout(hps_buff_dout),
    .hps_buff_wr(hps_buff_wr), .hps_buff_din(hps_buff_din)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  // Reference rule: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int off = 0; off < N; off++) begin
      if (m[(p + off) % N]) return (p + off) % N;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] one(input int d);
    return N'(1) << d;
  endfunction

  function automatic logic [N*LW-1:0] lba_vec(input int d, input logic [LW-1:0] v);
    logic [N*LW-1:0] r;
    r = '0;
    r[d*LW +: LW] = v;
    return r;
  endfunction

  task automatic raise_req(input int i, input int r, input logic [LW-1:0] lba, input logic [DW-1:0] din);
    cl_rd[i] = r[0];
    cl_wr[i] = r[1];
    cl_lba[i*LW +: LW] = lba;
    cl_buff_din[i*DW +: DW] = din;
    exp_lba[i] = lba;
    exp_din[i] = din;
    exp_wr[i]  = r[1];
  endtask

  task automatic do_reset;
    reset = 1'b1;
    cl_rd = '0; cl_wr = '0; hps_ack = '0;
    hps_buff_wr = 1'b0; hps_buff_addr = '0; hps_buff_dout = '0;
    repeat (2) tick;
    reset = 1'b0;
    tick;
    ptr_m = 0;
  endtask

  task automatic wait_issue(output int lat);
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      tick;
      if ((hps_rd | hps_wr) != '0) lat = c;
    end
  endtask

  task automatic wait_err(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 40 && cyc < 0; c++) begin
      tick;
      if (cl_err != '0) cyc = c;
    end
  endtask

  // Host side of one transfer: ack, n buffer strobes, ack release.
  task automatic serve(input int d, input int n, output int pulses, output int bad,
                       output logic [DW-1:0] din_seen, output logic [N-1:0] done_v,
                       output logic [N-1:0] err_v);
    logic [DW-1:0] dat;
    pulses = 0;
    bad = 0;
    hps_ack[d] = 1'b1;
    tick;
    din_seen = hps_buff_din;
    for (int k = 0; k < n; k++) begin
      dat = DW'($urandom);
      hps_buff_addr = AW'(k);
      hps_buff_dout = dat;
      hps_buff_wr = 1'b1;
      #1;
      if (cl_buff_wr == one(d)) pulses++;
      if ((cl_buff_wr & ~one(d)) != '0 || cl_buff_addr !== AW'(k) || cl_buff_dout !== dat) bad++;
      tick;
    end
    hps_buff_wr = 1'b0;
    hps_ack[d] = 1'b0;
    tick;
    done_v = cl_done;
    err_v = cl_err;
  endtask

  task automatic test_reset;
    logic [6*N-1:0] ctrl;
    reset = 1'b1;
    cl_rd = N'($urandom); cl_wr = N'($urandom); hps_ack = '1;
    hps_buff_wr = 1'b1; hps_buff_addr = '1; hps_buff_dout = '1;
    for (int i = 0; i < N; i++) raise_req(i, $urandom_range(1, 3), $urandom, DW'($urandom));
    repeat (2) tick;
    ctrl = {cl_busy, cl_done, cl_err, hps_rd, hps_wr, cl_buff_wr};
    tests++; if (ctrl !== '0) begin fails++; $display("FAIL reset_ctrl: got %h expected 0", ctrl); end
    tests++; if (hps_lba !== '0) begin fails++; $display("FAIL reset_lba: got %h expected 0", hps_lba); end
    tests++; if ({hps_buff_din, cl_buff_addr, cl_buff_dout} !== '0) begin
      fails++; $display("FAIL reset_bus: got %h expected 0", {hps_buff_din, cl_buff_addr, cl_buff_dout}); end
    do_reset;
    tick;
    ctrl = {cl_busy, cl_done, cl_err, hps_rd, hps_wr, cl_buff_wr};
    tests++; if (ctrl !== '0) begin fails++; $display("FAIL idle_ctrl: got %h expected 0", ctrl); end
  endtask

  task automatic test_single_read;
    int lat, pulses, bad;
    logic [DW-1:0] dseen;
    logic [N-1:0] dv, ev;
    for (int i = 0; i < N; i++) cl_lba[i*LW +: LW] = $urandom;
    raise_req(2, 1, 32'h1234, 8'h00);
    wait_issue(lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL rd_latency: got %0d expected 2", lat); end
    tests++; if (hps_rd !== 4'b0100 || hps_wr !== 4'b0000) begin
      fails++; $display("FAIL rd_issue: rd=%b wr=%b expected rd=0100 wr=0000", hps_rd, hps_wr); end
    tests++; if (cl_busy !== 4'b0100) begin fails++; $display("FAIL rd_busy: got %b expected 0100", cl_busy); end
    cl_lba[2*LW +: LW] = 32'hDEAD_BEEF;
    #1;
    tests++; if (hps_lba !== lba_vec(2, 32'h1234)) begin
      fails++; $display("FAIL rd_lba: got %h expected %h", hps_lba, lba_vec(2, 32'h1234)); end
    serve(2, 512, pulses, bad, dseen, dv, ev);
    tests++; if (pulses !== 512) begin fails++; $display("FAIL rd_strobes: got %0d expected 512", pulses); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL rd_bus: %0d bad beats expected 0", bad); end
    tests++; if (dv !== 4'b0100 || ev !== 4'b0000) begin
      fails++; $display("FAIL rd_done: done=%b err=%b expected done=0100 err=0000", dv, ev); end
    cl_rd[2] = 1'b0;
    tick;
    tests++; if (cl_done !== '0 || cl_busy !== '0) begin
      fails++; $display("FAIL rd_done_pulse: done=%b busy=%b expected 0", cl_done, cl_busy); end
    ptr_m = 3;
  endtask

  task automatic test_write_path;
    int lat, pulses, bad;
    logic [DW-1:0] dseen;
    logic [N-1:0] dv, ev;
    for (int i = 0; i < N; i++) cl_buff_din[i*DW +: DW] = DW'($urandom);
    raise_req(1, 2, $urandom, 8'hA5);
    #1;
    tests++; if (hps_buff_din !== 8'h00) begin fails++; $display("FAIL wr_din_idle: got %h expected 00", hps_buff_din); end
    wait_issue(lat);
    tests++; if (hps_wr !== 4'b0010 || hps_rd !== 4'b0000) begin
      fails++; $display("FAIL wr_issue: rd=%b wr=%b expected rd=0000 wr=0010", hps_rd, hps_wr); end
    serve(1, 16, pulses, bad, dseen, dv, ev);
    tests++; if (dseen !== 8'hA5) begin fails++; $display("FAIL wr_din_xfer: got %h expected a5", dseen); end
    tests++; if (pulses !== 16 || bad !== 0) begin
      fails++; $display("FAIL wr_strobes: got %0d/%0d bad expected 16/0", pulses, bad); end
    tests++; if (dv !== 4'b0010) begin fails++; $display("FAIL wr_done: got %b expected 0010", dv); end
    cl_wr[1] = 1'b0;
    tick;
    tests++; if (hps_buff_din !== 8'h00) begin fails++; $display("FAIL wr_din_after: got %h expected 00", hps_buff_din); end
    ptr_m = 2;
  endtask

  task automatic test_fairness;
    int lat, pulses, bad, order [5];
    logic [DW-1:0] dseen;
    logic [N-1:0] dv, ev;
    order = '{0, 1, 2, 3, 0};
    do_reset;
    for (int i = 0; i < N; i++) raise_req(i, 1, $urandom, DW'($urandom));
    for (int k = 0; k < 5; k++) begin
      wait_issue(lat);
      tests++; if (hps_rd !== one(order[k])) begin
        fails++; $display("FAIL fair_grant%0d: got %b expected %b", k, hps_rd, one(order[k])); end
      serve(order[k], 2, pulses, bad, dseen, dv, ev);
      tests++; if (dv !== one(order[k])) begin
        fails++; $display("FAIL fair_done%0d: got %b expected %b", k, dv, one(order[k])); end
      cl_rd[order[k]] = 1'b0;
      tick;
      cl_rd[order[k]] = 1'b1;
    end
    cl_rd = '0;
    repeat (3) tick;
    ptr_m = 1;
  endtask

  task automatic test_timeout;
    int lat, cyc, pulses, bad;
    logic [DW-1:0] dseen;
    logic [N-1:0] dv, ev;
    raise_req(3, 1, $urandom, DW'($urandom));
    wait_issue(lat);
    tests++; if (hps_rd !== 4'b1000) begin fails++; $display("FAIL to_issue: got %b expected 1000", hps_rd); end
    raise_req(1, 1, $urandom, DW'($urandom));
    wait_err(cyc);
    tests++; if (cyc !== 15) begin fails++; $display("FAIL to_cycle: got %0d expected 15", cyc); end
    tests++; if (cl_err !== 4'b1000 || cl_done !== 4'b0000) begin
      fails++; $display("FAIL to_err: err=%b done=%b expected err=1000 done=0000", cl_err, cl_done); end
    tests++; if ((hps_rd | hps_wr) !== '0) begin fails++; $display("FAIL to_drop: got %b expected 0", hps_rd | hps_wr); end
    cl_rd[3] = 1'b0;
    wait_issue(lat);
    tests++; if (hps_rd !== 4'b0010) begin fails++; $display("FAIL to_next: got %b expected 0010", hps_rd); end
    serve(1, 3, pulses, bad, dseen, dv, ev);
    tests++; if (dv !== 4'b0010) begin fails++; $display("FAIL to_next_done: got %b expected 0010", dv); end
    cl_rd[1] = 1'b0;
    ptr_m = 2;
  endtask

  task automatic test_spurious;
    int lat, pulses, bad;
    logic [DW-1:0] dseen;
    logic [N-1:0] dv, ev;
    raise_req(2, 3, $urandom, DW'($urandom));
    wait_issue(lat);
    tests++; if (hps_wr !== 4'b0100 || hps_rd !== 4'b0000) begin
      fails++; $display("FAIL sp_dir: rd=%b wr=%b expected rd=0000 wr=0100", hps_rd, hps_wr); end
    hps_ack[0] = 1'b1;
    hps_buff_wr = 1'b1;
    cl_wr[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      tests++; if (cl_buff_wr !== '0 || hps_wr !== 4'b0100 || cl_done !== '0) begin
        fails++; $display("FAIL sp_ignore%0d: buff_wr=%b hps_wr=%b done=%b expected 0000/0100/0000",
                          k, cl_buff_wr, hps_wr, cl_done); end
    end
    hps_ack[0] = 1'b0;
    hps_buff_wr = 1'b0;
    serve(2, 4, pulses, bad, dseen, dv, ev);
    tests++; if (pulses !== 4 || bad !== 0 || dv !== 4'b0100) begin
      fails++; $display("FAIL sp_xfer: pulses=%0d bad=%0d done=%b expected 4/0/0100", pulses, bad, dv); end
    cl_rd[2] = 1'b0;
    ptr_m = 3;
  endtask

  task automatic test_reset_mid_xfer;
    int lat, pulses, bad;
    logic [DW-1:0] dseen;
    logic [N-1:0] dv, ev, seen;
    raise_req(0, 1, $urandom, DW'($urandom));
    wait_issue(lat);
    hps_ack[0] = 1'b1;
    tick;
    hps_buff_wr = 1'b1;
    #1;
    tests++; if (cl_buff_wr !== 4'b0001) begin fails++; $display("FAIL rx_inxfer: got %b expected 0001", cl_buff_wr); end
    reset = 1'b1;
    tick;
    tests++; if ({cl_busy, cl_done, cl_err, hps_rd, hps_wr, cl_buff_wr} !== '0 || hps_lba !== '0 ||
                 {hps_buff_din, cl_buff_addr, cl_buff_dout} !== '0) begin
      fails++; $display("FAIL rx_outputs: ctrl=%h lba=%h expected 0",
                        {cl_busy, cl_done, cl_err, hps_rd, hps_wr, cl_buff_wr}, hps_lba); end
    cl_rd = '0; hps_ack = '0; hps_buff_wr = 1'b0;
    reset = 1'b0;
    seen = '0;
    for (int k = 0; k < 3; k++) begin
      tick;
      seen = seen | cl_done | cl_err;
    end
    tests++; if (seen !== '0) begin fails++; $display("FAIL rx_no_done: got %b expected 0", seen); end
    raise_req(3, 2, $urandom, DW'($urandom));
    wait_issue(lat);
    tests++; if (hps_wr !== 4'b1000 || lat !== 2) begin
      fails++; $display("FAIL rx_fresh: wr=%b lat=%0d expected 1000/2", hps_wr, lat); end
    serve(3, 5, pulses, bad, dseen, dv, ev);
    tests++; if (dv !== 4'b1000 || pulses !== 5) begin
      fails++; $display("FAIL rx_fresh_done: done=%b pulses=%0d expected 1000/5", dv, pulses); end
    cl_wr[3] = 1'b0;
    ptr_m = 0;
  endtask

  task automatic test_random;
    int lat, cyc, pulses, bad, e, n, pick;
    logic [DW-1:0] dseen;
    logic [N-1:0] dv, ev;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++)
        if (!(cl_rd[i] | cl_wr[i]) && $urandom_range(0, 1) == 1)
          raise_req(i, $urandom_range(1, 3), $urandom, DW'($urandom));
      if ((cl_rd | cl_wr) == '0) begin
        pick = $urandom_range(0, N - 1);
        raise_req(pick, $urandom_range(1, 3), $urandom, DW'($urandom));
      end
      e = rr_pick(cl_rd | cl_wr, ptr_m);
      wait_issue(lat);
      tests++; if (hps_rd !== (exp_wr[e] ? '0 : one(e)) || hps_wr !== (exp_wr[e] ? one(e) : '0)) begin
        fails++; $display("FAIL rnd%0d_grant: rd=%b wr=%b expected drive %0d wr=%0d", it, hps_rd, hps_wr, e, exp_wr[e]); end
      cl_lba[e*LW +: LW] = $urandom;
      #1;
      tests++; if (hps_lba !== lba_vec(e, exp_lba[e])) begin
        fails++; $display("FAIL rnd%0d_lba: got %h expected %h", it, hps_lba, lba_vec(e, exp_lba[e])); end
      if ($urandom_range(0, 4) == 0) begin
        wait_err(cyc);
        tests++; if (cyc !== 15 || cl_err !== one(e) || cl_done !== '0) begin
          fails++; $display("FAIL rnd%0d_timeout: cyc=%0d err=%b done=%b expected 15/%b/0", it, cyc, cl_err, cl_done, one(e)); end
      end else begin
        n = $urandom_range(1, 6);
        serve(e, n, pulses, bad, dseen, dv, ev);
        tests++; if (pulses !== n || bad !== 0 || dseen !== exp_din[e] || dv !== one(e) || ev !== '0) begin
          fails++; $display("FAIL rnd%0d_xfer: pulses=%0d bad=%0d din=%h done=%b err=%b expected %0d/0/%h/%b/0",
                            it, pulses, bad, dseen, dv, ev, n, exp_din[e], one(e)); end
      end
      $display("[TB] rnd %0d drive %0d wr=%0d lba=%h", it, e, exp_wr[e], exp_lba[e]);
      cl_rd[e] = 1'b0;
      cl_wr[e] = 1'b0;
      ptr_m = (e + 1) % N;
    end
    cl_rd = '0;
    cl_wr = '0;
    repeat (4) tick;
  endtask

  initial begin
    reset = 1'b1;
    cl_lba = '0; cl_rd = '0; cl_wr = '0; cl_buff_din = '0;
    hps_ack = '0; hps_buff_addr = '0; hps_buff_dout = '0; hps_buff_wr = 1'b0;
    test_reset;
    test_single_read;
    test_write_path;
    test_fairness;
    test_timeout;
    test_spurious;
    test_reset_mid_xfer;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
